// File: rtl/matrix_pkg.sv
// rtl/matrix_pkg.sv - shared constants, size codes and loader state for the matrix loader
package matrix_pkg;

    localparam int ELEM_W = 8;
    localparam int MAX_N  = 5;
    localparam int BUS_W  = ELEM_W * MAX_N * MAX_N;

    localparam logic [7:0] SIZE_2X2 = 8'd2;
    localparam logic [7:0] SIZE_3X3 = 8'd3;
    localparam logic [7:0] SIZE_4X4 = 8'd4;
    localparam logic [7:0] SIZE_5X5 = 8'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2
    } loader_state_t;

    function automatic logic is_legal_size(input logic [7:0] s);
        return (s >= SIZE_2X2) && (s <= SIZE_5X5);
    endfunction

endpackage

// File: rtl/matrix_index_gen.sv
// rtl/matrix_index_gen.sv - element counter and buffer byte index for the matrix loader
// MATRIX_LOADER_TRANSPOSE_EN selects column-major input (element c*N+r lands at byte r*N+c).
module matrix_index_gen
    import matrix_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clear,
    input  logic       advance,
    input  logic [2:0] size,
    output logic [4:0] idx,
    output logic       last
);

    logic [4:0] count;
    logic [4:0] total;

    assign last = (count == total - 5'd1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
            total <= '0;
        end else if (clear) begin
            count <= '0;
            total <= {2'b00, size} * {2'b00, size};
        end else if (advance) begin
            // Rewind after the final element so the counter never reaches N*N
            count <= last ? 5'd0 : count + 5'd1;
        end
    end

`ifdef MATRIX_LOADER_TRANSPOSE_EN
    logic [2:0] n;
    logic [2:0] row;
    logic [2:0] col;

    // Rows advance fastest because input arrives one column at a time
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            n   <= '0;
            row <= '0;
            col <= '0;
        end else if (clear) begin
            n   <= size;
            row <= '0;
            col <= '0;
        end else if (advance) begin
            if (last) begin
                row <= '0;
                col <= '0;
            end else if (row == n - 3'd1) begin
                row <= '0;
                col <= col + 3'd1;
            end else begin
                row <= row + 3'd1;
            end
        end
    end

    assign idx = {2'b00, row} * {2'b00, n} + {2'b00, col};
`else
    assign idx = count;
`endif

endmodule

// File: rtl/matrix_loader.sv
// rtl/matrix_loader.sv - assembles a streamed NxN matrix into the packed determinant bus
// MATRIX_LOADER_TRANSPOSE_EN (in matrix_index_gen) switches to column-major input.
module matrix_loader
    import matrix_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [7:0]        tamanho_in,
    input  logic              elem_valid,
    input  logic [ELEM_W-1:0] elem_data,
    output logic              elem_ready,
    output logic [BUS_W-1:0]  matriz_out,
    output logic [7:0]        tamanho_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              size_err
);

    loader_state_t    state;
    loader_state_t    state_next;
    logic [BUS_W-1:0] buffer;
    logic [BUS_W-1:0] buffer_next;
    logic [7:0]       size_reg;
    logic [4:0]       idx;
    logic             last;
    logic             start_ok;
    logic             start_bad;
    logic             accept;
    logic             finish;
    logic             release_mat;

    matrix_index_gen u_index_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (start_ok),
        .advance (accept),
        .size    (tamanho_in[2:0]),
        .idx     (idx),
        .last    (last)
    );

    // start outranks a same-cycle element in LOAD; HOLD only listens to out_ready
    always_comb begin
        state_next  = state;
        buffer_next = buffer;
        start_ok    = 1'b0;
        start_bad   = 1'b0;
        accept      = 1'b0;
        finish      = 1'b0;
        release_mat = 1'b0;
        case (state)
            IDLE, LOAD: begin
                if (start) begin
                    if (is_legal_size(tamanho_in)) begin
                        start_ok    = 1'b1;
                        buffer_next = '0;
                        state_next  = LOAD;
                    end else begin
                        start_bad  = 1'b1;
                        state_next = IDLE;
                    end
                end else if (state == LOAD && elem_valid && elem_ready) begin
                    accept = 1'b1;
                    buffer_next[idx*ELEM_W +: ELEM_W] = elem_data;
                    if (last) begin
                        finish     = 1'b1;
                        state_next = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    release_mat = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            buffer      <= '0;
            size_reg    <= '0;
            elem_ready  <= 1'b0;
            busy        <= 1'b0;
            size_err    <= 1'b0;
            matriz_out  <= '0;
            tamanho_out <= '0;
            out_valid   <= 1'b0;
        end else begin
            buffer     <= buffer_next;
            elem_ready <= (state_next == LOAD);
            busy       <= (state_next != IDLE);
            if (start_ok) begin
                size_reg <= tamanho_in;
                size_err <= 1'b0;
            end
            if (start_bad) begin
                size_err <= 1'b1;
            end
            // The final element goes straight into the published bus on the same edge
            if (finish) begin
                matriz_out  <= buffer_next;
                tamanho_out <= size_reg;
                out_valid   <= 1'b1;
            end
            if (release_mat) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_matrix_loader.sv
// tb/tb_matrix_loader.sv - scoreboard bench for matrix_loader with a row/column-major reference model
module tb_matrix_loader;

    typedef struct {
        logic [199:0] bus;
        logic [7:0]   sz;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic [7:0]   tamanho_in;
    logic         elem_valid;
    logic [7:0]   elem_data;
    logic         elem_ready;
    logic [199:0] matriz_out;
    logic [7:0]   tamanho_out;
    logic         out_valid;
    logic         out_ready;
    logic         busy;
    logic         size_err;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t sb[$];

    matrix_loader dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .tamanho_in  (tamanho_in),
        .elem_valid  (elem_valid),
        .elem_data   (elem_data),
        .elem_ready  (elem_ready),
        .matriz_out  (matriz_out),
        .tamanho_out (tamanho_out),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy),
        .size_err    (size_err)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: element k of an NxN matrix lands at byte k (row-major) or at its transpose position
    function automatic logic [199:0] model(input int n, input logic [7:0] el[$]);
        logic [199:0] m;
        m = '0;
        for (int k = 0; k < n * n; k++) begin
            int pos;
`ifdef MATRIX_LOADER_TRANSPOSE_EN
            pos = (k % n) * n + (k / n);
`else
            pos = k;
`endif
            m[pos*8 +: 8] = el[k];
        end
        return m;
    endfunction

    // Monitor: every completed handshake must match the oldest expected matrix
    initial begin
        logic         held;
        logic [199:0] held_bus;
        logic [7:0]   held_sz;
        exp_t         e;
        held = 1'b0;
        held_bus = '0;
        held_sz = '0;
        forever begin
            @(negedge clk);
            if (reset_n && out_valid) begin
                if (held) begin
                    chk("hold_bus_stable", matriz_out, held_bus);
                    chk("hold_size_stable", tamanho_out, held_sz);
                end
                if (out_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_output", 1'b1, 1'b0);
                    end else begin
                        e = sb.pop_front();
                        chk("sb_matriz_out", matriz_out, e.bus);
                        chk("sb_tamanho_out", tamanho_out, e.sz);
                    end
                    held = 1'b0;
                end else begin
                    held     = 1'b1;
                    held_bus = matriz_out;
                    held_sz  = tamanho_out;
                end
            end else begin
                held = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [7:0] sz);
        start      = 1'b1;
        tamanho_in = sz;
        step();
        start = 1'b0;
    endtask

    task automatic feed(input int cnt, input logic [7:0] el[$], input int vprob, output logic ok);
        int   k;
        int   guard;
        logic acc;
        k = 0;
        guard = 0;
        while (k < cnt && guard < 2000) begin
            elem_valid = ($urandom_range(0, 99) < vprob);
            elem_data  = el[k];
            acc = elem_valid && elem_ready;
            step();
            if (acc) k++;
            guard++;
        end
        elem_valid = 1'b0;
        ok = (k == cnt);
    endtask

    task automatic wait_valid(output int at);
        int g;
        g = 0;
        while (!out_valid && g < 300) begin
            step();
            g++;
        end
        if (!out_valid) chk("wait_out_valid_timeout", 1'b0, 1'b1);
        at = cyc;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    // Start, stream, queue the expectation, wait for out_valid; leaves the matrix in HOLD
    task automatic load(input int n, input logic [7:0] el[$], input int vprob, input logic chk_lat);
        int   t0;
        int   t1;
        logic ok;
        exp_t e;
        do_start(n[7:0]);
        t0 = cyc;
        feed(n * n, el, vprob, ok);
        chk("feed_complete", ok, 1'b1);
        e.bus = model(n, el);
        e.sz  = n[7:0];
        sb.push_back(e);
        wait_valid(t1);
        if (chk_lat) chk("latency", t1 - t0, n * n);
    endtask

    initial begin
        logic [7:0]   el[$];
        logic [7:0]   ff[$];
        logic [199:0] exp_bus;
        logic [199:0] last_bus;
        logic         ok;
        logic         seen;
        int           n;

        reset_n    = 1'b0;
        start      = 1'b0;
        tamanho_in = '0;
        elem_valid = 1'b0;
        elem_data  = '0;
        out_ready  = 1'b0;
        #1;
        step();
        step();
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_elem_ready", elem_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_size_err", size_err, 1'b0);
        chk("rst_matriz_out", matriz_out, '0);
        chk("rst_tamanho_out", tamanho_out, '0);
        reset_n = 1'b1;
        step();

        // 2x2 directed
        el = '{8'd3, 8'd1, 8'd2, 8'd4};
        load(2, el, 100, 1'b1);
`ifdef MATRIX_LOADER_TRANSPOSE_EN
        chk("2x2_low_word", matriz_out[31:0], 32'h04010203);
`else
        chk("2x2_low_word", matriz_out[31:0], 32'h04020103);
`endif
        chk("2x2_upper_zero", matriz_out[199:32], '0);
        chk("2x2_tamanho_out", tamanho_out, 8'd2);
        handshake();

        // 5x5 with a long hold, start ignored in HOLD
        el = {};
        for (int k = 0; k < 25; k++) el.push_back(8'(k + 1));
        load(5, el, 100, 1'b1);
        exp_bus = model(5, el);
        repeat (10) step();
        chk("hold_out_valid", out_valid, 1'b1);
        chk("hold_busy", busy, 1'b1);
        do_start(8'd2);
        chk("hold_start_ignored_valid", out_valid, 1'b1);
        chk("hold_start_ignored_size", tamanho_out, 8'd5);
        start = 1'b1;
        tamanho_in = 8'd3;
        handshake();
        start = 1'b0;
        chk("release_out_valid", out_valid, 1'b0);
        chk("release_busy", busy, 1'b0);
        chk("release_elem_ready", elem_ready, 1'b0);
        chk("release_keeps_bus", matriz_out, exp_bus);
        chk("release_keeps_size", tamanho_out, 8'd5);

        // Illegal size, then legal 3x3 with 1..9
        do_start(8'd7);
        chk("illegal_size_err", size_err, 1'b1);
        chk("illegal_elem_ready", elem_ready, 1'b0);
        chk("illegal_busy", busy, 1'b0);
        step();
        chk("illegal_stays_idle", elem_ready, 1'b0);
        el = {};
        for (int k = 0; k < 9; k++) el.push_back(8'(k + 1));
        do_start(8'd3);
        chk("legal_clears_err", size_err, 1'b0);
        chk("legal_busy", busy, 1'b1);
        chk("legal_elem_ready", elem_ready, 1'b1);
        feed(9, el, 100, ok);
        chk("feed_complete", ok, 1'b1);
        sb.push_back('{model(3, el), 8'd3});
        wait_valid(n);
`ifdef MATRIX_LOADER_TRANSPOSE_EN
        chk("3x3_bytes", matriz_out[71:0], 72'h090603080502070401);
`else
        chk("3x3_bytes", matriz_out[71:0], 72'h090807060504030201);
`endif
        handshake();

        // Elements in IDLE are ignored; abort a 4x4 after 5 elements with a 3x3 restart
        elem_valid = 1'b1;
        elem_data  = 8'hA5;
        repeat (3) step();
        elem_valid = 1'b0;
        el = {};
        for (int k = 0; k < 16; k++) el.push_back(8'($urandom));
        do_start(8'd4);
        feed(5, el, 50, ok);
        chk("abort_partial_feed", ok, 1'b1);
        start      = 1'b1;
        tamanho_in = 8'd3;
        elem_valid = 1'b1;
        elem_data  = 8'h55;
        step();
        start      = 1'b0;
        elem_valid = 1'b0;
        ff = {};
        for (int k = 0; k < 9; k++) ff.push_back(8'hFF);
        feed(9, ff, 50, ok);
        chk("abort_refeed", ok, 1'b1);
        sb.push_back('{model(3, ff), 8'd3});
        wait_valid(n);
        chk("abort_bytes_ff", matriz_out[71:0], {9{8'hFF}});
        chk("abort_bytes_zero", matriz_out[199:72], '0);
        chk("abort_tamanho_out", tamanho_out, 8'd3);
        handshake();

        // Reset in the middle of a 2x2 load
        last_bus = matriz_out;
        chk("pre_reset_bus_nonzero", (last_bus != '0), 1'b1);
        el = '{8'd9, 8'd8, 8'd7, 8'd6};
        do_start(8'd2);
        feed(2, el, 100, ok);
        reset_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_elem_ready", elem_ready, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_matriz_out", matriz_out, '0);
        chk("midrst_tamanho_out", tamanho_out, '0);
        step();
        reset_n = 1'b1;
        elem_valid = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (out_valid) seen = 1'b1;
        end
        elem_valid = 1'b0;
        chk("no_partial_matrix", seen, 1'b0);
        load(2, el, 100, 1'b1);
        handshake();

        // Randomised loads, illegal sizes and consumer delays
        for (int t = 0; t < 24; t++) begin
            if ($urandom_range(0, 4) == 0) begin
                case ($urandom_range(0, 3))
                    0: n = 0;
                    1: n = 1;
                    2: n = 6;
                    default: n = 255;
                endcase
                do_start(n[7:0]);
                chk("rand_illegal_err", size_err, 1'b1);
                chk("rand_illegal_busy", busy, 1'b0);
            end else begin
                n = $urandom_range(2, 5);
                el = {};
                for (int k = 0; k < n * n; k++) el.push_back(8'($urandom));
                load(n, el, $urandom_range(30, 100), 1'b0);
                repeat ($urandom_range(0, 4)) step();
                handshake();
            end
        end

        repeat (3) step();
        chk("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1);
    end

endmodule
